param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_W, default 12, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-003 Parameter AF_LEVEL, default DEPTH-2, level at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 2, level at or below which almost_empty asserts.
REQ-005 Localparam ADDR_W = $clog2(DEPTH); not overridable.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 flush  in  1  synchronous clear of contents, active high.
REQ-009 wr_en  in  1  write request, active high.
REQ-010 wr_data  in  DATA_W  write data.
REQ-011 rd_en  in  1  read request (pop), active high.
REQ-012 rd_data  out  DATA_W  head-of-queue data, first-word fall-through.
REQ-013 full / empty  out  1 each  level==DEPTH / level==0.
REQ-014 almost_full / almost_empty  out  1 each  level>=AF_LEVEL / level<=AE_LEVEL.
REQ-015 level  out  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-016 overflow_err / underflow_err  out  1 each  sticky error flags.
REQ-017 clr_err  in  1  synchronous clear of both sticky error flags.

Function
REQ-018 Pointers shall be ADDR_W+1 bits; level = wr_ptr - rd_ptr modulo 2^(ADDR_W+1); index = low ADDR_W bits; wrap bit provides full/empty disambiguation.
REQ-019 Read accepted (rd_acc) when rd_en & ~empty; rd_ptr increments next edge.
REQ-020 Write accepted (wr_acc) when wr_en & (~full | rd_acc); mem[wr_ptr] <= wr_data and wr_ptr increments next edge.
REQ-021 Full with simultaneous wr_en and rd_en: both accepted, level unchanged, no error.
REQ-022 Empty with simultaneous wr_en and rd_en: write accepted, read rejected, underflow_err set.
REQ-023 rd_data shall equal mem[rd_ptr] combinationally (zero-latency head); value undefined-but-stable when empty; a word written at edge N is visible on rd_data after edge N.
REQ-024 All flags and level derived combinationally from registered pointers only (no input paths), update the cycle after the accepted access.
REQ-025 overflow_err sets when wr_en & ~wr_acc; underflow_err sets when rd_en & empty; both hold until clr_err or reset; set has priority over clr_err in the same cycle.
REQ-026 flush shall zero both pointers at next edge and override wr_en/rd_en in that cycle; memory contents untouched; error flags unaffected.
REQ-027 Pointer wrap-around past 2^(ADDR_W+1)-1 to 0 shall be seamless, no flag glitch.

Reset
REQ-028 rst_n low: wr_ptr=rd_ptr=0, overflow_err=underflow_err=0 immediately; hence empty=1, almost_empty=1, full=0, almost_full=0 (if AF_LEVEL>0), level=0.
REQ-029 Memory array shall not be reset; reset mid-operation discards all contents.

Configuration
REQ-030 Macro PARAM_FIFO_ERR_EN defined: REQ-025 error logic compiled in.
REQ-031 Macro undefined: error registers absent, overflow_err and underflow_err tied 0, clr_err ignored; ports unchanged.

Structure
REQ-032 Shared package fifo_pkg: default DATA_W/DEPTH constants and a level-compare helper function.
REQ-033 One sub-module fifo_ptr (ADDR_W+1-bit counter with inc and clr inputs), instantiated twice for wr and rd pointers.

Verification (DATA_W=12, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-034 Reset then write 0x001..0x008 -> full=1 after 8th edge, level=8, almost_full from level 6; read 8 -> rd_data 0x001..0x008 in order, empty=1.
REQ-035 Full, wr_en=1 alone with 0xABC -> write dropped, level stays 8, overflow_err=1 until clr_err pulse then 0.
REQ-036 Full, wr_en=rd_en=1 for 20 cycles -> level stays 8, data order preserved across pointer wrap, no error flags.
REQ-037 Empty, wr_en=rd_en=1 with 0x5A5 -> level=1, rd_data=0x5A5, underflow_err=1.
REQ-038 Level 5, flush=1 with wr_en=1 -> level=0, empty=1 next cycle; rst_n pulsed low mid-stream -> flags reset asynchronously before next edge.
REQ-039 Build without PARAM_FIFO_ERR_EN, repeat REQ-035/REQ-037 stimulus -> error outputs remain 0, data behaviour identical.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: default sizing constants and level-compare helpers shared by the
// FIFO top and its sub-modules.
package fifo_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_DEPTH  = 8;

  // True when an occupancy value is at or above a threshold.
  function automatic logic level_ge(input int unsigned lvl, input int unsigned thr);
    return (lvl >= thr);
  endfunction

  // True when an occupancy value is at or below a threshold.
  function automatic logic level_le(input int unsigned lvl, input int unsigned thr);
    return (lvl <= thr);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-around pointer counter with synchronous clear and increment.
// Clear wins over increment so a flush always lands the pointer on zero.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next pointer value: clear, advance (modulo 2^PTR_W) or hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Pointer register with asynchronous reset to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous first-word-fall-through FIFO with occupancy flags,
// level output, flush and optional sticky overflow/underflow flags.
// Define PARAM_FIFO_ERR_EN to build the sticky error flags; otherwise they
// read constant 0 and clr_err has no effect.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow_err,
  output logic                       underflow_err,
  input  logic                       clr_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] mem [DEPTH];

  // Occupancy and flags come from the registered pointers only; the extra
  // wrap bit separates full (difference DEPTH) from empty (difference 0).
  assign level        = wr_ptr - rd_ptr;
  assign empty        = (level == '0);
  assign full         = (level == DEPTH_L);
  assign almost_full  = level_ge(int'(level), AF_LEVEL);
  assign almost_empty = level_le(int'(level), AE_LEVEL);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write
  // alongside a read.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  fifo_ptr #(.PTR_W(ADDR_W + 1)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (wr_acc & ~flush),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.PTR_W(ADDR_W + 1)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (rd_acc & ~flush),
    .ptr   (rd_ptr)
  );

  // Storage write; flush suppresses the write along with the pointer moves.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; reset only clears the pointers, which discards the contents.
    if (wr_acc && !flush) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Head of queue presented with no read latency.
  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

`ifdef PARAM_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic ovf_set, unf_set;

  // A flush cycle ignores the requests, so it cannot raise an error either.
  assign ovf_set = wr_en & ~wr_acc & ~flush;
  assign unf_set = rd_en & empty & ~flush;

  // Sticky flags: set beats clear when both happen in one cycle.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (unf_set) unf_d = 1'b1;
  end

  // Error flag registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow_err   = 1'b0;
  assign underflow_err  = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed self-checking bench for param_fifo
// (DATA_W=12, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2). Expected error flag values
// follow whether PARAM_FIFO_ERR_EN is defined for the build.
module tb_param_fifo;

`ifdef PARAM_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        wr_en;
  logic [11:0] wr_data;
  logic        rd_en;
  logic [11:0] rd_data;
  logic        full, empty, almost_full, almost_empty;
  logic [3:0]  level;
  logic        overflow_err, underflow_err;
  logic        clr_err;

  int total_checks;
  int failed_checks;
  logic [11:0] q [$];
  logic [11:0] exp_w;

  param_fifo #(
    .DATA_W(12), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .level         (level),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .clr_err       (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) else begin
      failed_checks++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_checks  = 0;
    failed_checks = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    #1;
    check("reset_empty", empty, 1);
    check("reset_aempty", almost_empty, 1);
    check("reset_full", full, 0);
    check("reset_afull", almost_full, 0);
    check("reset_level", level, 0);
    check("reset_ovf", overflow_err, 0);
    check("reset_unf", underflow_err, 0);
    step();
    step();
    rst_n = 1'b1;

    // Fill with 0x001..0x008.
    for (int i = 1; i <= 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 12'(i);
      step();
      check("fill_level", level, i);
      check("fill_afull", almost_full, (i >= 6));
      check("fill_aempty", almost_empty, (i <= 2));
      check("fill_full", full, (i == 8));
    end
    wr_en = 1'b0;

    // Drain and check order.
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      check("drain_data", rd_data, i);
      step();
      check("drain_level", level, 8 - i);
    end
    rd_en = 1'b0;
    check("drain_empty", empty, 1);
    check("drain_full", full, 0);

    // Refill to full with 0x011..0x018.
    for (int i = 1; i <= 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 12'(16 + i);
      q.push_back(12'(16 + i));
      step();
    end
    check("refill_full", full, 1);

    // Write into full FIFO is dropped.
    wr_data = 12'hABC;
    step();
    wr_en = 1'b0;
    check("ovf_level", level, 8);
    check("ovf_head", rd_data, 12'h011);
    check("ovf_flag", overflow_err, ERR_EN);
    step();
    check("ovf_sticky", overflow_err, ERR_EN);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_clr", overflow_err, 0);

    // Simultaneous read+write on full for 20 cycles, wraps pointers.
    for (int k = 0; k < 20; k++) begin
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 12'h100 + 12'(k);
      exp_w   = q.pop_front();
      check("rw_head", rd_data, exp_w);
      q.push_back(12'h100 + 12'(k));
      step();
      check("rw_level", level, 8);
      check("rw_full", full, 1);
    end
    wr_en = 1'b0;
    check("rw_ovf", overflow_err, 0);
    check("rw_unf", underflow_err, 0);

    // Drain wrapped contents in order.
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      exp_w = q.pop_front();
      check("wrap_data", rd_data, exp_w);
      step();
    end
    rd_en = 1'b0;
    check("wrap_empty", empty, 1);
    check("wrap_unf_none", underflow_err, 0);

    // Simultaneous read+write on empty: write only, underflow.
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 12'h5A5;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("unf_level", level, 1);
    check("unf_data", rd_data, 12'h5A5);
    check("unf_flag", underflow_err, ERR_EN);
    check("unf_no_ovf", overflow_err, 0);

    // Reach level 5, then flush with a concurrent write.
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = 12'h300 + 12'(i);
      step();
    end
    wr_en = 1'b0;
    check("pre_flush_level", level, 5);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 12'h777;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    check("flush_err_kept", underflow_err, ERR_EN);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("unf_clr", underflow_err, 0);

    // Underflow on empty, then partial fill, then async reset mid-cycle.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("unf2_flag", underflow_err, ERR_EN);
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 12'h400 + 12'(i);
      step();
    end
    wr_en = 1'b0;
    check("pre_rst_level", level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", level, 0);
    check("arst_empty", empty, 1);
    check("arst_aempty", almost_empty, 1);
    check("arst_unf", underflow_err, 0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_empty", empty, 1);

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
